// File: rtl/control_pkg.sv
// rtl/control_pkg.sv - shared encodings for the multicycle main controller
package control_pkg;

  // Controller states, one per sequencing step of an instruction
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9
  } state_t;

  // ALU operation codes driven on ALU_control
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_ORR = 4'b0011;

  // Instruction cmd field values
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  // Instruction op field values
  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  // Condition codes
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  // ALU_src_B selections
  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // result_src selections
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  // Map an instruction cmd field onto an ALU operation; unknown cmds add
  function automatic logic [3:0] decode_cmd(input logic [3:0] cmd);
    case (cmd)
      CMD_ADD: decode_cmd = ALU_ADD;
      CMD_SUB: decode_cmd = ALU_SUB;
      CMD_AND: decode_cmd = ALU_AND;
      CMD_ORR: decode_cmd = ALU_ORR;
      default: decode_cmd = ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/cond_check.sv
// rtl/cond_check.sv - NZCV flags register and condition evaluation
module cond_check
  import control_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] cond_i,
  input  logic [3:0] alu_flags_i,
  input  logic       flag_update_i,
  input  logic       arith_i,
  output logic [3:0] flags_o,
  output logic       cond_ex_o
);

  logic [3:0] flags_q;
  logic       n_f, z_f, c_f, v_f;
  logic       nz_we, cv_we;

  assign {n_f, z_f, c_f, v_f} = flags_q;

  // A failed condition suppresses the flag write too; logical ops leave C and V alone
  assign nz_we = flag_update_i & cond_ex_o;
  assign cv_we = nz_we & arith_i;

  // Evaluate the condition against the flags as they stood before this instruction
  always_comb begin
    cond_ex_o = 1'b0;
    case (cond_i)
      COND_EQ: cond_ex_o = z_f;
      COND_NE: cond_ex_o = ~z_f;
      COND_CS: cond_ex_o = c_f;
      COND_CC: cond_ex_o = ~c_f;
      COND_MI: cond_ex_o = n_f;
      COND_PL: cond_ex_o = ~n_f;
      COND_VS: cond_ex_o = v_f;
      COND_VC: cond_ex_o = ~v_f;
      COND_HI: cond_ex_o = c_f & ~z_f;
      COND_LS: cond_ex_o = ~c_f | z_f;
      COND_GE: cond_ex_o = (n_f == v_f);
      COND_LT: cond_ex_o = (n_f != v_f);
      COND_GT: cond_ex_o = ~z_f & (n_f == v_f);
      COND_LE: cond_ex_o = z_f | (n_f != v_f);
      COND_AL: cond_ex_o = 1'b1;
      default: cond_ex_o = 1'b0;
    endcase
  end

  // Flags register with separate N/Z and C/V write enables
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= 4'b0000;
    end else begin
      if (nz_we) flags_q[3:2] <= alu_flags_i[3:2];
      if (cv_we) flags_q[1:0] <= alu_flags_i[1:0];
    end
  end

  assign flags_o = flags_q;

endmodule

// File: rtl/control_multiciclo.sv
// rtl/control_multiciclo.sv - multicycle Moore main controller
module control_multiciclo
  import control_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] cond,
  input  logic [1:0] op,
  input  logic [5:0] funct,
  input  logic [3:0] rd,
  input  logic [3:0] ALU_flags,
  output logic       PC_write,
  output logic       adr_src,
  output logic       IR_write,
  output logic       mem_write,
  output logic       reg_write,
  output logic       ALU_src_A,
  output logic [1:0] ALU_src_B,
  output logic [3:0] ALU_control,
  output logic [1:0] result_src,
  output logic [1:0] imm_src,
  output logic [1:0] reg_src,
  output logic [3:0] flags
);

  state_t     state_q, state_d;
  logic       cond_ex;
  logic [3:0] alu_op;
  logic       in_execute;
  logic       flag_update;
  logic       arith;
  logic       rd_is_pc;

  assign alu_op      = decode_cmd(funct[4:1]);
  assign in_execute  = (state_q == S_EXECUTER) || (state_q == S_EXECUTEI);
  assign flag_update = in_execute & funct[0];
  assign arith       = (alu_op == ALU_ADD) || (alu_op == ALU_SUB);
  assign rd_is_pc    = (rd == 4'b1111);

  cond_check u_cond_check (
    .clk          (clk),
    .rst_n        (rst_n),
    .cond_i       (cond),
    .alu_flags_i  (ALU_flags),
    .flag_update_i(flag_update),
    .arith_i      (arith),
    .flags_o      (flags),
    .cond_ex_o    (cond_ex)
  );

  // State register; reset parks the sequencer in FETCH at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Next-state sequencing
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_MEM:  state_d = S_MEMADR;
          OP_DP:   state_d = funct[5] ? S_EXECUTEI : S_EXECUTER;
          OP_BR:   state_d = S_BRANCH;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = funct[0] ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = S_MEMWB;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      default:    state_d = S_FETCH;
    endcase
  end

  // Moore output decode, with architectural writes gated by cond_ex
  always_comb begin
    PC_write    = 1'b0;
    adr_src     = 1'b0;
    IR_write    = 1'b0;
    mem_write   = 1'b0;
    reg_write   = 1'b0;
    ALU_src_A   = 1'b0;
    ALU_src_B   = SRCB_REG;
    ALU_control = ALU_ADD;
    result_src  = RES_ALUOUT;
    case (state_q)
      S_FETCH: begin
        IR_write   = 1'b1;
        ALU_src_A  = 1'b1;
        ALU_src_B  = SRCB_FOUR;
        result_src = RES_ALU;
        PC_write   = 1'b1;
      end
      S_DECODE: begin
        ALU_src_A  = 1'b1;
        ALU_src_B  = SRCB_FOUR;
        result_src = RES_ALU;
      end
      S_MEMADR: begin
        ALU_src_B = SRCB_IMM;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = cond_ex;
      end
      S_MEMWB: begin
        result_src = RES_MEM;
        reg_write  = cond_ex & ~rd_is_pc;
        PC_write   = cond_ex & rd_is_pc;
      end
      S_EXECUTER: begin
        ALU_src_B   = SRCB_REG;
        ALU_control = alu_op;
      end
      S_EXECUTEI: begin
        ALU_src_B   = SRCB_IMM;
        ALU_control = alu_op;
      end
      S_ALUWB: begin
        result_src = RES_ALUOUT;
        reg_write  = cond_ex & ~rd_is_pc;
        PC_write   = cond_ex & rd_is_pc;
      end
      S_BRANCH: begin
        ALU_src_B  = SRCB_IMM;
        result_src = RES_ALU;
        PC_write   = cond_ex;
      end
      default: ;
    endcase
  end

  assign imm_src = op;
  assign reg_src = {op == OP_MEM, op == OP_BR};

endmodule

// File: tb/tb_control_multiciclo.sv
// tb/tb_control_multiciclo.sv - self-checking bench for control_multiciclo
module tb_control_multiciclo;
  import control_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] cond = 4'b0;
  logic [1:0] op = 2'b0;
  logic [5:0] funct = 6'b0;
  logic [3:0] rd = 4'b0;
  logic [3:0] ALU_flags = 4'b0;
  logic       PC_write, adr_src, IR_write, mem_write, reg_write, ALU_src_A;
  logic [1:0] ALU_src_B, result_src, imm_src, reg_src;
  logic [3:0] ALU_control, flags;

  control_multiciclo dut (
    .clk(clk), .rst_n(rst_n), .cond(cond), .op(op), .funct(funct), .rd(rd),
    .ALU_flags(ALU_flags), .PC_write(PC_write), .adr_src(adr_src),
    .IR_write(IR_write), .mem_write(mem_write), .reg_write(reg_write),
    .ALU_src_A(ALU_src_A), .ALU_src_B(ALU_src_B), .ALU_control(ALU_control),
    .result_src(result_src), .imm_src(imm_src), .reg_src(reg_src), .flags(flags)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Bench-side phase names: fetch, decode, address, read, mem-writeback,
  // mem-write, exec-reg, exec-imm, alu-writeback, branch
  localparam int P_F = 0, P_D = 1, P_A = 2, P_R = 3, P_MW = 4, P_S = 5,
                 P_ER = 6, P_EI = 7, P_W = 8, P_B = 9;

  logic [3:0]  mflags = 4'b0;
  logic [21:0] exp_vec = '0;
  logic        chk_en = 1'b0;
  string       cur_name = "";
  int          cur_phase = 0;
  wire  [21:0] dut_vec = {PC_write, adr_src, IR_write, mem_write, reg_write, ALU_src_A,
                          ALU_src_B, ALU_control, result_src, imm_src, reg_src, flags};

  function automatic logic holds(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy && !z;
      4'd9:  return !cy || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] alu_of(input logic [3:0] cmd);
    if (cmd == 4'b0010) return 4'b0001;
    if (cmd == 4'b0000) return 4'b0010;
    if (cmd == 4'b1100) return 4'b0011;
    return 4'b0000;
  endfunction

  function automatic logic [21:0] expect_out(input int p, input logic [3:0] c, input logic [1:0] o,
                                             input logic [5:0] f, input logic [3:0] r,
                                             input logic [3:0] fl);
    logic pc, adr, ir, mw, rw, a, ce;
    logic [1:0] b, res;
    logic [3:0] alu;
    ce = holds(c, fl);
    pc = 0; adr = 0; ir = 0; mw = 0; rw = 0; a = 0; b = 2'b00; res = 2'b00; alu = 4'b0000;
    case (p)
      P_F:  begin ir = 1; a = 1; b = 2'b10; res = 2'b10; pc = 1; end
      P_D:  begin a = 1; b = 2'b10; res = 2'b10; end
      P_A:  b = 2'b01;
      P_R:  adr = 1;
      P_S:  begin adr = 1; mw = ce; end
      P_MW: begin res = 2'b01; if (r == 4'd15) pc = ce; else rw = ce; end
      P_ER: alu = alu_of(f[4:1]);
      P_EI: begin b = 2'b01; alu = alu_of(f[4:1]); end
      P_W:  begin if (r == 4'd15) pc = ce; else rw = ce; end
      P_B:  begin b = 2'b01; res = 2'b10; pc = ce; end
      default: ;
    endcase
    return {pc, adr, ir, mw, rw, a, b, alu, res, o, {o == 2'b01, o == 2'b10}, fl};
  endfunction

  // Single compare process: checks every cycle the driver marks as meaningful
  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (dut_vec !== exp_vec) begin
        errors++;
        $display("FAIL %s phase %0d got %b want %b", cur_name, cur_phase, dut_vec, exp_vec);
      end
    end
  end

  task automatic check1(input string name, input logic [3:0] got, input logic [3:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %b want %b", name, got, want);
    end
  endtask

  // Drive one instruction from FETCH and follow it through every phase.
  // abort_at >= 0 stops after checking that phase, leaving the DUT mid-instruction.
  task automatic run(input string name, input logic [3:0] c, input logic [1:0] o,
                     input logic [5:0] f, input logic [3:0] r, input logic [3:0] af,
                     input int abort_at);
    int ph[$];
    logic ce;
    cond = c; op = o; funct = f; rd = r; ALU_flags = af;
    ph = {P_F, P_D};
    case (o)
      2'b00: ph = {ph, (f[5] ? P_EI : P_ER), P_W};
      2'b01: ph = f[0] ? {ph, P_A, P_R, P_MW} : {ph, P_A, P_S};
      2'b10: ph.push_back(P_B);
      default: ;
    endcase
    for (int i = 0; i < ph.size(); i++) begin
      cur_name = name;
      cur_phase = i;
      exp_vec = expect_out(ph[i], c, o, f, r, mflags);
      chk_en = 1'b1;
      if (i == abort_at) begin
        @(negedge clk);
        #1;
        chk_en = 1'b0;
        return;
      end
      ce = holds(c, mflags);
      @(posedge clk);
      if ((ph[i] == P_ER || ph[i] == P_EI) && f[0] && ce) begin
        if (alu_of(f[4:1]) == 4'b0000 || alu_of(f[4:1]) == 4'b0001) mflags = af;
        else mflags = {af[3:2], mflags[1:0]};
      end
      #1;
    end
    chk_en = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #2 rst_n = 1'b0;
    #1;
    check1("reset_state", {3'b0, dut.state_q == S_FETCH}, 4'b0001);
    check1("reset_flags", flags, 4'b0000);
    check1("reset_fetch_en", {2'b0, IR_write, PC_write}, 4'b0011);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    run("add_imm", 4'b1110, 2'b00, 6'b101000, 4'd2, 4'b1111, -1);
    check1("add_imm_flags", flags, 4'b0000);
    run("sub_s", 4'b1110, 2'b00, 6'b000101, 4'd1, 4'b0100, -1);
    check1("sub_s_flags", flags, 4'b0100);
    run("eq_taken", 4'b0000, 2'b00, 6'b001000, 4'd3, 4'b0000, -1);
    run("ne_skipped", 4'b0001, 2'b00, 6'b001000, 4'd3, 4'b0000, -1);
    run("add_s", 4'b1110, 2'b00, 6'b001001, 4'd4, 4'b0011, -1);
    check1("add_s_flags", flags, 4'b0011);
    run("orr_s", 4'b1110, 2'b00, 6'b011001, 4'd5, 4'b1000, -1);
    check1("orr_s_flags", flags, 4'b1011);
    run("and_s", 4'b1110, 2'b00, 6'b000001, 4'd6, 4'b0110, -1);
    check1("and_s_flags", flags, 4'b0111);
    run("ne_s_skip", 4'b0001, 2'b00, 6'b001001, 4'd6, 4'b1111, -1);
    check1("ne_s_skip_flags", flags, 4'b0111);
    run("ldr", 4'b1110, 2'b01, 6'b011001, 4'd7, 4'b0000, -1);
    run("str", 4'b1110, 2'b01, 6'b011000, 4'd7, 4'b0000, -1);
    run("b_al", 4'b1110, 2'b10, 6'b000000, 4'd0, 4'b0000, -1);
    run("b_nv", 4'b1111, 2'b10, 6'b000000, 4'd0, 4'b0000, -1);
    run("alu_rd15", 4'b1110, 2'b00, 6'b001000, 4'd15, 4'b0000, -1);
    run("nop_op11", 4'b1110, 2'b11, 6'b000000, 4'd0, 4'b0000, -1);
    run("subi", 4'b1110, 2'b00, 6'b100100, 4'd8, 4'b0000, -1);
    run("cmd_other", 4'b1110, 2'b00, 6'b011110, 4'd9, 4'b0000, -1);
    run("ldr_rd15_gt", 4'b1100, 2'b01, 6'b011001, 4'd15, 4'b0000, -1);

    run("ldr_abort", 4'b1110, 2'b01, 6'b011001, 4'd5, 4'b0000, 3);
    rst_n = 1'b0;
    #1;
    check1("abort_state", {3'b0, dut.state_q == S_FETCH}, 4'b0001);
    check1("abort_flags", flags, 4'b0000);
    check1("abort_fetch_en", {2'b0, IR_write, PC_write}, 4'b0011);
    mflags = 4'b0000;
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    check1("release_fetch_en", {2'b0, IR_write, PC_write}, 4'b0011);
    run("eq_after_reset", 4'b0000, 2'b00, 6'b001000, 4'd15, 4'b0000, -1);
    run("ldr_after_reset", 4'b1110, 2'b01, 6'b011001, 4'd2, 4'b0000, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
